id_ex_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 32 +++
 rtl/id_ex_stage_if.sv | 69 ++++++
 rtl/id_ex_stage_fwd_sel.sv | 33 +++
 rtl/id_ex_stage.sv | 109 ++++++++++
 tb/tb_id_ex_stage.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: datapath widths, ALU/writeback encodings and
// the decoded control bundle carried from ID into EX.
package cpu_pkg;

  localparam int DATA_W  = 32;
  localparam int RA_W    = 5;
  localparam int ALUOP_W = 6;
  localparam int CNT_W   = 16;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 6'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 6'd1;
  localparam logic [ALUOP_W-1:0] ALU_AND = 6'd2;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 6'd3;
  localparam logic [ALUOP_W-1:0] ALU_XOR = 6'd4;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 6'd5;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 6'd6;
  localparam logic [ALUOP_W-1:0] ALU_SRL = 6'd7;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  typedef struct packed {
    logic               regwr;
    logic               memrd;
    logic               memwr;
    logic               alusrc;
    logic [1:0]         memtoreg;
    logic [ALUOP_W-1:0] aluop;
  } id_ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between the decoder/bypass network and the ID/EX boundary.
// The master drives decode, bypass and control inputs; the slave is the stage.
interface id_ex_stage_if;
  import cpu_pkg::*;

  logic               id_valid;
  logic [DATA_W-1:0]  id_pc;
  logic [DATA_W-1:0]  id_imm;
  logic [RA_W-1:0]    id_rs;
  logic [RA_W-1:0]    id_rt;
  logic [RA_W-1:0]    id_rd;
  logic               id_use_rs;
  logic               id_use_rt;
  logic               id_regwr;
  logic               id_memrd;
  logic               id_memwr;
  logic               id_alusrc;
  logic [1:0]         id_memtoreg;
  logic [ALUOP_W-1:0] id_aluop;
  logic [DATA_W-1:0]  rf_rdata_a;
  logic [DATA_W-1:0]  rf_rdata_b;
  logic               ex_fw_regwr;
  logic               ex_fw_memrd;
  logic [RA_W-1:0]    ex_fw_addr;
  logic [DATA_W-1:0]  ex_fw_data;
  logic               mem_fw_regwr;
  logic [RA_W-1:0]    mem_fw_addr;
  logic [DATA_W-1:0]  mem_fw_data;
  logic               wb_fw_regwr;
  logic [RA_W-1:0]    wb_fw_addr;
  logic [DATA_W-1:0]  wb_fw_data;
  logic               flush;
  logic               ex_hold;

  logic               id_ready;
  logic               ex_valid;
  logic               ex_regwr;
  logic               ex_memrd;
  logic               ex_memwr;
  logic               ex_alusrc;
  logic [1:0]         ex_memtoreg;
  logic [ALUOP_W-1:0] ex_aluop;
  logic [DATA_W-1:0]  ex_pc;
  logic [DATA_W-1:0]  ex_opa;
  logic [DATA_W-1:0]  ex_opb;
  logic [DATA_W-1:0]  ex_imm;
  logic [RA_W-1:0]    ex_rd;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output id_valid, id_pc, id_imm, id_rs, id_rt, id_rd, id_use_rs, id_use_rt,
           id_regwr, id_memrd, id_memwr, id_alusrc, id_memtoreg, id_aluop,
           rf_rdata_a, rf_rdata_b, ex_fw_regwr, ex_fw_memrd, ex_fw_addr,
           ex_fw_data, mem_fw_regwr, mem_fw_addr, mem_fw_data, wb_fw_regwr,
           wb_fw_addr, wb_fw_data, flush, ex_hold,
    input  id_ready, ex_valid, ex_regwr, ex_memrd, ex_memwr, ex_alusrc,
           ex_memtoreg, ex_aluop, ex_pc, ex_opa, ex_opb, ex_imm, ex_rd, stall_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_imm, id_rs, id_rt, id_rd, id_use_rs, id_use_rt,
           id_regwr, id_memrd, id_memwr, id_alusrc, id_memtoreg, id_aluop,
           rf_rdata_a, rf_rdata_b, ex_fw_regwr, ex_fw_memrd, ex_fw_addr,
           ex_fw_data, mem_fw_regwr, mem_fw_addr, mem_fw_data, wb_fw_regwr,
           wb_fw_addr, wb_fw_data, flush, ex_hold,
    output id_ready, ex_valid, ex_regwr, ex_memrd, ex_memwr, ex_alusrc,
           ex_memtoreg, ex_aluop, ex_pc, ex_opa, ex_opb, ex_imm, ex_rd, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage_fwd_sel.sv
// Operand bypass mux: EX > MEM > WB > register file, r0 reads as zero and an
// in-flight load in EX is never a bypass source.
module fwd_sel
  import cpu_pkg::*;
(
  input  logic [RA_W-1:0]   i_addr,
  input  logic [DATA_W-1:0] i_rf_data,
  input  logic              i_ex_regwr,
  input  logic              i_ex_memrd,
  input  logic [RA_W-1:0]   i_ex_addr,
  input  logic [DATA_W-1:0] i_ex_data,
  input  logic              i_mem_regwr,
  input  logic [RA_W-1:0]   i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_wb_regwr,
  input  logic [RA_W-1:0]   i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0] o_data
);

  always_comb begin
    o_data = i_rf_data;
    if (i_addr == '0)
      o_data = '0;
    else if (i_ex_regwr && !i_ex_memrd && (i_ex_addr == i_addr))
      o_data = i_ex_data;
    else if (i_mem_regwr && (i_mem_addr == i_addr))
      o_data = i_mem_data;
    else if (i_wb_regwr && (i_wb_addr == i_addr))
      o_data = i_wb_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX boundary: operand bypass, load-use hazard detection, the ID/EX
// pipeline register and a saturating load-use stall counter.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);

  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;
  logic              w_lu;
  logic              w_bubble;
  id_ctrl_t          w_id_ctrl;

  logic              r_valid;
  id_ctrl_t          r_ctrl;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic [DATA_W-1:0] r_imm;
  logic [RA_W-1:0]   r_rd;
  logic [CNT_W-1:0]  r_stall_cnt;

  fwd_sel u_fwd_a (
    .i_addr(bus.id_rs), .i_rf_data(bus.rf_rdata_a),
    .i_ex_regwr(bus.ex_fw_regwr), .i_ex_memrd(bus.ex_fw_memrd),
    .i_ex_addr(bus.ex_fw_addr), .i_ex_data(bus.ex_fw_data),
    .i_mem_regwr(bus.mem_fw_regwr), .i_mem_addr(bus.mem_fw_addr),
    .i_mem_data(bus.mem_fw_data), .i_wb_regwr(bus.wb_fw_regwr),
    .i_wb_addr(bus.wb_fw_addr), .i_wb_data(bus.wb_fw_data), .o_data(w_opa)
  );

  fwd_sel u_fwd_b (
    .i_addr(bus.id_rt), .i_rf_data(bus.rf_rdata_b),
    .i_ex_regwr(bus.ex_fw_regwr), .i_ex_memrd(bus.ex_fw_memrd),
    .i_ex_addr(bus.ex_fw_addr), .i_ex_data(bus.ex_fw_data),
    .i_mem_regwr(bus.mem_fw_regwr), .i_mem_addr(bus.mem_fw_addr),
    .i_mem_data(bus.mem_fw_data), .i_wb_regwr(bus.wb_fw_regwr),
    .i_wb_addr(bus.wb_fw_addr), .i_wb_data(bus.wb_fw_data), .o_data(w_opb)
  );

  // A load in EX delivers its data only from MEM, so a consumer must wait one cycle.
  assign w_lu = bus.id_valid && bus.ex_fw_memrd && bus.ex_fw_regwr &&
                (bus.ex_fw_addr != '0) &&
                ((bus.id_use_rs && (bus.id_rs == bus.ex_fw_addr)) ||
                 (bus.id_use_rt && (bus.id_rt == bus.ex_fw_addr)));

  assign w_bubble = bus.flush || w_lu || !bus.id_valid;
  assign bus.id_ready = bus.id_valid && !w_lu && !bus.ex_hold && !bus.flush;

  assign w_id_ctrl = '{regwr: bus.id_regwr, memrd: bus.id_memrd,
                       memwr: bus.id_memwr, alusrc: bus.id_alusrc,
                       memtoreg: bus.id_memtoreg, aluop: bus.id_aluop};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_pc    <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_imm   <= '0;
      r_rd    <= '0;
    end else if (bus.ex_hold) begin
      r_valid <= r_valid;
    end else if (w_bubble) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_pc    <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_imm   <= '0;
      r_rd    <= '0;
    end else begin
      r_valid <= 1'b1;
      r_ctrl  <= w_id_ctrl;
      r_pc    <= bus.id_pc;
      r_opa   <= w_opa;
      r_opb   <= w_opb;
      r_imm   <= bus.id_imm;
      r_rd    <= bus.id_rd;
    end
  end

  // Only stalls that actually cost a cycle are counted; flush or hold already stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_stall_cnt <= '0;
    else if (w_lu && !bus.flush && !bus.ex_hold && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign bus.ex_valid    = r_valid;
  assign bus.ex_regwr    = r_ctrl.regwr;
  assign bus.ex_memrd    = r_ctrl.memrd;
  assign bus.ex_memwr    = r_ctrl.memwr;
  assign bus.ex_alusrc   = r_ctrl.alusrc;
  assign bus.ex_memtoreg = r_ctrl.memtoreg;
  assign bus.ex_aluop    = r_ctrl.aluop;
  assign bus.ex_pc       = r_pc;
  assign bus.ex_opa      = r_opa;
  assign bus.ex_opb      = r_opb;
  assign bus.ex_imm      = r_imm;
  assign bus.ex_rd       = r_rd;
  assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: behavioural reference model compared every
// negedge, plus directed scenarios pinned with hand-computed literals.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  id_ex_stage_if bus ();

  id_ex_stage dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // model state: what the EX-side register must hold
  logic              m_valid;
  logic [11:0]       m_ctrl;
  logic [DATA_W-1:0] m_pc, m_opa, m_opb, m_imm;
  logic [RA_W-1:0]   m_rd;
  int                m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand value from the spec's rules: walk the sources in priority order.
  function automatic logic [DATA_W-1:0] m_fwd(input logic [RA_W-1:0] a, input logic [DATA_W-1:0] rf);
    logic              en  [3];
    logic [RA_W-1:0]   ad  [3];
    logic [DATA_W-1:0] dat [3];
    if (a == 0) return 0;
    en[0] = bus.ex_fw_regwr & ~bus.ex_fw_memrd; ad[0] = bus.ex_fw_addr;  dat[0] = bus.ex_fw_data;
    en[1] = bus.mem_fw_regwr;                   ad[1] = bus.mem_fw_addr; dat[1] = bus.mem_fw_data;
    en[2] = bus.wb_fw_regwr;                    ad[2] = bus.wb_fw_addr;  dat[2] = bus.wb_fw_data;
    for (int k = 0; k < 3; k++)
      if (en[k] && ad[k] == a) return dat[k];
    return rf;
  endfunction

  function automatic bit m_lu();
    bit hit_rs, hit_rt;
    if (!(bus.id_valid && bus.ex_fw_memrd && bus.ex_fw_regwr && bus.ex_fw_addr != 0)) return 0;
    hit_rs = bus.id_use_rs && (bus.id_rs == bus.ex_fw_addr);
    hit_rt = bus.id_use_rt && (bus.id_rt == bus.ex_fw_addr);
    return hit_rs || hit_rt;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid = 0; m_ctrl = 0; m_pc = 0; m_opa = 0; m_opb = 0; m_imm = 0; m_rd = 0; m_cnt = 0;
    end else begin
      if (m_lu() && !bus.flush && !bus.ex_hold && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (!bus.ex_hold) begin
        if (bus.flush || m_lu() || !bus.id_valid) begin
          m_valid = 0; m_ctrl = 0; m_pc = 0; m_opa = 0; m_opb = 0; m_imm = 0; m_rd = 0;
        end else begin
          m_valid = 1;
          m_ctrl  = {bus.id_regwr, bus.id_memrd, bus.id_memwr, bus.id_alusrc,
                     bus.id_memtoreg, bus.id_aluop};
          m_pc    = bus.id_pc;
          m_opa   = m_fwd(bus.id_rs, bus.rf_rdata_a);
          m_opb   = m_fwd(bus.id_rt, bus.rf_rdata_b);
          m_imm   = bus.id_imm;
          m_rd    = bus.id_rd;
        end
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    chk("m_valid", 64'(bus.ex_valid), 64'(m_valid));
    chk("m_ctrl", 64'({bus.ex_regwr, bus.ex_memrd, bus.ex_memwr, bus.ex_alusrc,
                       bus.ex_memtoreg, bus.ex_aluop}), 64'(m_ctrl));
    chk("m_pc_imm", {bus.ex_pc, bus.ex_imm}, {m_pc, m_imm});
    chk("m_opa", 64'(bus.ex_opa), 64'(m_opa));
    chk("m_opb", 64'(bus.ex_opb), 64'(m_opb));
    chk("m_rd", 64'(bus.ex_rd), 64'(m_rd));
    chk("m_stall_cnt", 64'(bus.stall_cnt), 64'(m_cnt));
    chk("m_id_ready", 64'(bus.id_ready),
        64'(bus.id_valid && !m_lu() && !bus.ex_hold && !bus.flush));
  end

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_pc = 0; bus.id_imm = 0; bus.id_rs = 0; bus.id_rt = 0;
    bus.id_rd = 0; bus.id_use_rs = 0; bus.id_use_rt = 0; bus.id_regwr = 0;
    bus.id_memrd = 0; bus.id_memwr = 0; bus.id_alusrc = 0; bus.id_memtoreg = 0;
    bus.id_aluop = 0; bus.rf_rdata_a = 0; bus.rf_rdata_b = 0;
    bus.ex_fw_regwr = 0; bus.ex_fw_memrd = 0; bus.ex_fw_addr = 0; bus.ex_fw_data = 0;
    bus.mem_fw_regwr = 0; bus.mem_fw_addr = 0; bus.mem_fw_data = 0;
    bus.wb_fw_regwr = 0; bus.wb_fw_addr = 0; bus.wb_fw_data = 0;
    bus.flush = 0; bus.ex_hold = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic random_inputs();
    bus.id_valid    = ($urandom_range(0, 9) != 0);
    bus.id_pc       = $urandom; bus.id_imm = $urandom;
    bus.id_rs       = 5'($urandom_range(0, 3)); bus.id_rt = 5'($urandom_range(0, 3));
    bus.id_rd       = 5'($urandom);
    bus.id_use_rs   = 1'($urandom); bus.id_use_rt = 1'($urandom);
    bus.id_regwr    = 1'($urandom); bus.id_memrd = 1'($urandom);
    bus.id_memwr    = 1'($urandom); bus.id_alusrc = 1'($urandom);
    bus.id_memtoreg = 2'($urandom); bus.id_aluop = 6'($urandom);
    bus.rf_rdata_a  = $urandom; bus.rf_rdata_b = $urandom;
    bus.ex_fw_regwr = 1'($urandom); bus.ex_fw_memrd = ($urandom_range(0, 2) == 0);
    bus.ex_fw_addr  = 5'($urandom_range(0, 3)); bus.ex_fw_data = $urandom;
    bus.mem_fw_regwr = 1'($urandom); bus.mem_fw_addr = 5'($urandom_range(0, 3));
    bus.mem_fw_data = $urandom;
    bus.wb_fw_regwr = 1'($urandom); bus.wb_fw_addr = 5'($urandom_range(0, 3));
    bus.wb_fw_data  = $urandom;
    bus.flush       = ($urandom_range(0, 9) == 0);
    bus.ex_hold     = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    clear_inputs();
    #1;
    chk("reset_ex_valid", 64'(bus.ex_valid), 0);
    chk("reset_stall_cnt", 64'(bus.stall_cnt), 0);
    chk("reset_id_ready", 64'(bus.id_ready), 0);
    @(negedge clk); @(negedge clk);
    reset = 1;
    $display("reset released");

    // no hazards
    step();
    bus.id_valid = 1; bus.id_rs = 3; bus.id_use_rs = 1; bus.rf_rdata_a = 32'h11;
    #1 chk("plain_id_ready", 64'(bus.id_ready), 1);
    step();
    chk("plain_opa", 64'(bus.ex_opa), 64'h11);
    chk("plain_valid", 64'(bus.ex_valid), 1);
    $display("txn plain: opa=0x%0h", bus.ex_opa);

    // forwarding priority
    bus.id_rs = 5; bus.ex_fw_regwr = 1; bus.ex_fw_addr = 5; bus.ex_fw_data = 32'hAAAA;
    bus.mem_fw_regwr = 1; bus.mem_fw_addr = 5; bus.mem_fw_data = 32'hBBBB;
    bus.wb_fw_regwr = 1; bus.wb_fw_addr = 5; bus.wb_fw_data = 32'hCCCC;
    step(); chk("prio_ex", 64'(bus.ex_opa), 64'hAAAA);
    bus.ex_fw_regwr = 0;
    step(); chk("prio_mem", 64'(bus.ex_opa), 64'hBBBB);
    bus.mem_fw_regwr = 0;
    step(); chk("prio_wb", 64'(bus.ex_opa), 64'hCCCC);
    $display("txn priority: final opa=0x%0h", bus.ex_opa);

    // load-use
    clear_inputs();
    bus.id_valid = 1; bus.id_rt = 8; bus.id_use_rt = 1; bus.rf_rdata_b = 32'h5;
    bus.ex_fw_regwr = 1; bus.ex_fw_memrd = 1; bus.ex_fw_addr = 8; bus.ex_fw_data = 32'hDEAD;
    #1 chk("lu_id_ready", 64'(bus.id_ready), 0);
    step();
    chk("lu_bubble", 64'(bus.ex_valid), 0);
    chk("lu_stall_cnt", 64'(bus.stall_cnt), 1);
    bus.ex_fw_regwr = 0; bus.ex_fw_memrd = 0;
    bus.mem_fw_regwr = 1; bus.mem_fw_addr = 8; bus.mem_fw_data = 32'h1234;
    step();
    chk("lu_mem_opb", 64'(bus.ex_opb), 64'h1234);
    chk("lu_valid", 64'(bus.ex_valid), 1);
    $display("txn load-use: opb=0x%0h stall_cnt=%0d", bus.ex_opb, bus.stall_cnt);

    // r0 guard
    clear_inputs();
    bus.id_valid = 1; bus.id_rs = 0; bus.id_use_rs = 1; bus.rf_rdata_a = 32'h5;
    bus.ex_fw_regwr = 1; bus.ex_fw_memrd = 1; bus.ex_fw_addr = 0; bus.ex_fw_data = 32'hFFFF;
    bus.mem_fw_regwr = 1; bus.mem_fw_data = 32'hFFFF;
    bus.wb_fw_regwr = 1; bus.wb_fw_data = 32'hFFFF;
    #1 chk("r0_id_ready", 64'(bus.id_ready), 1);
    step();
    chk("r0_opa", 64'(bus.ex_opa), 0);
    chk("r0_stall_cnt", 64'(bus.stall_cnt), 1);
    $display("txn r0: opa=0x%0h", bus.ex_opa);

    // flush together with load-use
    clear_inputs();
    bus.id_valid = 1; bus.id_rs = 4; bus.id_use_rs = 1; bus.flush = 1;
    bus.ex_fw_regwr = 1; bus.ex_fw_memrd = 1; bus.ex_fw_addr = 4;
    step();
    chk("flush_lu_bubble", 64'(bus.ex_valid), 0);
    chk("flush_lu_cnt", 64'(bus.stall_cnt), 1);
    $display("txn flush+lu: stall_cnt=%0d", bus.stall_cnt);

    // ex_hold freezes the register
    clear_inputs();
    bus.id_valid = 1; bus.id_rs = 3; bus.id_use_rs = 1; bus.rf_rdata_a = 32'h77;
    bus.id_pc = 32'h400;
    step();
    bus.ex_hold = 1; bus.rf_rdata_a = 32'h99; bus.id_pc = 32'h404;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_id_ready", 64'(bus.id_ready), 0);
      step();
      chk("hold_opa", 64'(bus.ex_opa), 64'h77);
      chk("hold_pc", 64'(bus.ex_pc), 64'h400);
      chk("hold_valid", 64'(bus.ex_valid), 1);
    end
    $display("txn hold: opa=0x%0h pc=0x%0h", bus.ex_opa, bus.ex_pc);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      random_inputs();
      step();
    end
    $display("random phase done");

    // saturation
    clear_inputs();
    bus.id_valid = 1; bus.id_rs = 9; bus.id_use_rs = 1;
    bus.ex_fw_regwr = 1; bus.ex_fw_memrd = 1; bus.ex_fw_addr = 9;
    for (int i = 0; i < 32'h10001; i++) step();
    chk("sat_stall_cnt", 64'(bus.stall_cnt), 64'hFFFF);
    $display("txn saturation: stall_cnt=0x%0h", bus.stall_cnt);

    // asynchronous reset mid-cycle after loading an instruction
    clear_inputs();
    bus.id_valid = 1; bus.id_rs = 2; bus.id_use_rs = 1; bus.rf_rdata_a = 32'h55;
    bus.id_rd = 7; bus.id_regwr = 1;
    step();
    chk("pre_reset_valid", 64'(bus.ex_valid), 1);
    #2 reset = 0;
    #1;
    chk("async_valid", 64'(bus.ex_valid), 0);
    chk("async_opa", 64'(bus.ex_opa), 0);
    chk("async_rd_regwr", 64'({bus.ex_rd, bus.ex_regwr}), 0);
    chk("async_stall_cnt", 64'(bus.stall_cnt), 0);
    @(negedge clk); reset = 1;
    step();
    chk("post_reset_opa", 64'(bus.ex_opa), 64'h55);
    for (int i = 0; i < 200; i++) begin
      random_inputs();
      step();
    end

    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
